sv32_page_table_walker: RTL and testbench

- Hardware Sv32 page table walker; sequences the two-level walk on a TLB miss.
- Takes a virtual address and the current satp, privilege and mstatus fields, and reads PTEs through a single memory port.
- Checks permissions and performs the A/D write-back when needed.
- Returns a physical page number or a page fault to the requesting TLB (I-side or D-side; an external arbiter selects one).

---
 rtl/sv32_page_table_walker.sv | 218 +++++++++++++++++++++
 tb/tb_sv32_page_table_walker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_page_table_walker.sv
`default_nettype none
// sv32_page_table_walker: two-level Sv32 walk with permission check and A/D write-back.
// Rev 1.0 - one memory transaction in flight; each result is held until the requester takes it.
module sv32_page_table_walker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [1:0]  req_access,
    input  logic [1:0]  req_priv,
    input  logic        satp_mode,
    input  logic [21:0] satp_ppn,
    input  logic        status_sum,
    input  logic        status_mxr,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [21:0] resp_ppn,
    output logic        resp_superpage,
    output logic        resp_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [33:0] mem_req_addr,
    output logic        mem_req_write,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_L1_REQ  = 4'd1,
        S_L1_WAIT = 4'd2,
        S_L0_REQ  = 4'd3,
        S_L0_WAIT = 4'd4,
        S_AD_REQ  = 4'd5,
        S_AD_WAIT = 4'd6,
        S_DONE    = 4'd7,
        S_DRAIN   = 4'd8
    } state_e;

    state_e      state_q;
    logic [9:0]  vpn0_q;
    logic [1:0]  access_q;
    logic [1:0]  priv_q;
    logic        sum_q;
    logic        mxr_q;
    logic [21:0] resp_ppn_q;
    logic        resp_superpage_q;
    logic        resp_fault_q;
    logic [33:0] mem_addr_q;
    logic        mem_write_q;
    logic [31:0] mem_wdata_q;

    logic        w_v, w_r, w_w, w_x, w_u, w_a, w_d;
    logic        w_fetch, w_store, w_at_l1;
    logic        w_perm_ok, w_pte_bad, w_pte_leaf, w_misaligned;
    logic        w_walk_fault, w_need_ad;
    logic [21:0] w_leaf_ppn;
    logic [31:0] w_ad_pte;
    state_e      w_wait_state;
    logic        w_unused;

    assign w_v = mem_resp_data[0];
    assign w_r = mem_resp_data[1];
    assign w_w = mem_resp_data[2];
    assign w_x = mem_resp_data[3];
    assign w_u = mem_resp_data[4];
    assign w_a = mem_resp_data[6];
    assign w_d = mem_resp_data[7];

    assign w_fetch = (access_q == 2'd0);
    assign w_store = access_q[1];
    assign w_at_l1 = (state_q == S_L1_WAIT);

    // Leaf permission check against the access type and effective privilege
    always_comb begin
        w_perm_ok = 1'b1;
        case (access_q)
            2'd0:    if (!w_x) w_perm_ok = 1'b0;
            2'd1:    if (!(w_r || (mxr_q && w_x))) w_perm_ok = 1'b0;
            default: if (!w_w) w_perm_ok = 1'b0;
        endcase
        if (priv_q == 2'd0) begin
            if (!w_u) w_perm_ok = 1'b0;
        end else if (w_u && (!sum_q || w_fetch)) begin
            w_perm_ok = 1'b0;
        end
    end

    assign w_pte_bad    = !w_v || (!w_r && w_w);
    assign w_pte_leaf   = w_r || w_x;
    assign w_misaligned = w_at_l1 && (mem_resp_data[19:10] != 10'd0);
    assign w_walk_fault = w_pte_bad
                        || (w_pte_leaf && (w_misaligned || !w_perm_ok))
                        || (!w_pte_leaf && !w_at_l1);
    assign w_need_ad    = !w_a || (w_store && !w_d);
    assign w_leaf_ppn   = w_at_l1 ? {mem_resp_data[31:20], vpn0_q} : mem_resp_data[31:10];
    assign w_ad_pte     = mem_resp_data | 32'h0000_0040 | (w_store ? 32'h0000_0080 : 32'h0);

    always_comb begin
        w_wait_state = S_AD_WAIT;
        case (state_q)
            S_L1_REQ: w_wait_state = S_L1_WAIT;
            S_L0_REQ: w_wait_state = S_L0_WAIT;
            default:  w_wait_state = S_AD_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            vpn0_q           <= 10'd0;
            access_q         <= 2'd0;
            priv_q           <= 2'd0;
            sum_q            <= 1'b0;
            mxr_q            <= 1'b0;
            resp_ppn_q       <= 22'd0;
            resp_superpage_q <= 1'b0;
            resp_fault_q     <= 1'b0;
            mem_addr_q       <= 34'd0;
            mem_write_q      <= 1'b0;
            mem_wdata_q      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!flush && req_valid) begin
                        vpn0_q           <= req_vaddr[21:12];
                        access_q         <= req_access;
                        priv_q           <= req_priv;
                        sum_q            <= status_sum;
                        mxr_q            <= status_mxr;
                        mem_write_q      <= 1'b0;
                        mem_wdata_q      <= 32'd0;
                        resp_fault_q     <= 1'b0;
                        resp_superpage_q <= 1'b0;
                        if (!satp_mode || (req_priv == 2'd3)) begin
                            resp_ppn_q <= {2'b00, req_vaddr[31:12]};
                            state_q    <= S_DONE;
                        end else begin
                            resp_ppn_q <= 22'd0;
                            mem_addr_q <= {satp_ppn, req_vaddr[31:22], 2'b00};
                            state_q    <= S_L1_REQ;
                        end
                    end
                end
                S_L1_REQ, S_L0_REQ, S_AD_REQ: begin
                    // A request already handed over must still have its response drained
                    if (flush) begin
                        state_q <= mem_req_ready ? S_DRAIN : S_IDLE;
                    end else if (mem_req_ready) begin
                        state_q <= w_wait_state;
                    end
                end
                S_L1_WAIT, S_L0_WAIT: begin
                    if (flush) begin
                        state_q <= mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_resp_valid) begin
                        if (w_walk_fault) begin
                            resp_ppn_q       <= 22'd0;
                            resp_superpage_q <= 1'b0;
                            resp_fault_q     <= 1'b1;
                            state_q          <= S_DONE;
                        end else if (!w_pte_leaf) begin
                            mem_addr_q <= {mem_resp_data[31:10], vpn0_q, 2'b00};
                            state_q    <= S_L0_REQ;
                        end else begin
                            resp_ppn_q       <= w_leaf_ppn;
                            resp_superpage_q <= w_at_l1;
                            resp_fault_q     <= 1'b0;
                            if (w_need_ad) begin
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= w_ad_pte;
                                state_q     <= S_AD_REQ;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_AD_WAIT: begin
                    if (flush) begin
                        state_q <= mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_resp_valid) begin
                        mem_write_q <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_DONE);
    assign resp_ppn       = resp_ppn_q;
    assign resp_superpage = resp_superpage_q;
    assign resp_fault     = resp_fault_q;
    assign mem_req_valid  = (state_q == S_L1_REQ) || (state_q == S_L0_REQ) || (state_q == S_AD_REQ);
    assign mem_req_addr   = mem_addr_q;
    assign mem_req_write  = mem_write_q;
    assign mem_req_wdata  = mem_wdata_q;

    assign w_unused = ^{req_vaddr[11:0], mem_resp_data[9:8], mem_resp_data[5]};

endmodule
`default_nettype wire

// File: tb/tb_sv32_page_table_walker.sv
`default_nettype none
// tb_sv32_page_table_walker: directed walks against a small PTE memory model
// with hand-computed translations, faults, A/D write-backs and flush behaviour.
module tb_sv32_page_table_walker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_vaddr = 32'd0;
    logic [1:0]  req_access = 2'd0;
    logic [1:0]  req_priv = 2'd0;
    logic        satp_mode = 1'b0;
    logic [21:0] satp_ppn = 22'd0;
    logic        status_sum = 1'b0;
    logic        status_mxr = 1'b0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [21:0] resp_ppn;
    logic        resp_superpage;
    logic        resp_fault;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [33:0] mem_req_addr;
    logic        mem_req_write;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    always #5 clk = ~clk;

    sv32_page_table_walker u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_vaddr      (req_vaddr),
        .req_access     (req_access),
        .req_priv       (req_priv),
        .satp_mode      (satp_mode),
        .satp_ppn       (satp_ppn),
        .status_sum     (status_sum),
        .status_mxr     (status_mxr),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_ppn       (resp_ppn),
        .resp_superpage (resp_superpage),
        .resp_fault     (resp_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_write  (mem_req_write),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    localparam logic [21:0] ROOT  = 22'h000100;
    localparam logic [33:0] L1A   = 34'h0_0010_0004;  // vaddr 0x0040_3000, vpn1=1
    localparam logic [33:0] L0A   = 34'h0_0010_000C;  // pointer ppn 0x100, vpn0=3
    localparam logic [33:0] L1A_0 = 34'h0_0010_0000;  // vaddr 0

    logic [31:0] mem [logic [33:0]];
    logic [33:0] rd_q [$];
    int          n_wr = 0;
    logic [33:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [33:0] slow_addr = '1;
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: accepts immediately, answers one cycle later (four for slow_addr reads)
    initial begin : p_mem
        logic [33:0] a;
        int          dly;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid && mem_req_ready) begin
                a = mem_req_addr;
                if (mem_req_write) begin
                    n_wr++;
                    wr_addr = a;
                    wr_data = mem_req_wdata;
                    mem[a]  = mem_req_wdata;
                end else begin
                    rd_q.push_back(a);
                end
                dly = (a == slow_addr && !mem_req_write) ? 4 : 1;
                @(posedge clk); #1;
                for (int i = 1; i < dly; i++) begin
                    @(posedge clk); #1;
                end
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem.exists(a) ? mem[a] : 32'h0;
                @(posedge clk); #1;
                mem_resp_valid = 1'b0;
            end
        end
    end

    task automatic clr();
        mem.delete();
        rd_q.delete();
        n_wr    = 0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    // Present one request; scramble the sampled inputs right after acceptance
    task automatic start_req(input string tag, input logic mode, input logic [31:0] va,
                             input logic [1:0] acc, input logic [1:0] pv,
                             input logic sum, input logic mxr);
        check({tag, ".req_ready"}, req_ready, 1'b1);
        satp_mode  = mode;
        satp_ppn   = ROOT;
        req_vaddr  = va;
        req_access = acc;
        req_priv   = pv;
        status_sum = sum;
        status_mxr = mxr;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        satp_ppn   = ~ROOT;
        req_vaddr  = ~va;
        status_sum = ~sum;
        status_mxr = ~mxr;
        satp_mode  = ~mode;
        req_access = ~acc;
    endtask

    task automatic wait_resp(input string tag, output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check({tag, ".timeout"}, 1'b0, 1'b1);
    endtask

    task automatic walk(input string tag, input logic mode, input logic [31:0] va,
                        input logic [1:0] acc, input logic [1:0] pv, input logic sum,
                        input logic mxr, input logic [21:0] e_ppn, input logic e_sp,
                        input logic e_f, input int e_lat);
        int lat;
        start_req(tag, mode, va, acc, pv, sum, mxr);
        wait_resp(tag, lat);
        check({tag, ".lat"},   lat,            e_lat);
        check({tag, ".ppn"},   resp_ppn,       e_ppn);
        check({tag, ".sp"},    resp_superpage, e_sp);
        check({tag, ".fault"}, resp_fault,     e_f);
        @(negedge clk);
        check({tag, ".hold"},  {resp_valid, resp_ppn}, {1'b1, e_ppn});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : p_main
        int   lat;
        int   t_resp;
        int   t_rdy;
        logic seen_rv;

        @(negedge clk);
        check("rst.req_ready", req_ready, 1'b1);
        check("rst.resp", {resp_valid, resp_ppn, resp_superpage, resp_fault}, 25'd0);
        check("rst.mem", {mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata}, 68'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bare and M-mode bypass
        clr();
        walk("bare", 1'b0, 32'h8000_1234, 2'd1, 2'd1, 1'b0, 1'b0, 22'h080001, 1'b0, 1'b0, 1);
        walk("mmode", 1'b1, 32'h1234_5678, 2'd2, 2'd3, 1'b0, 1'b0, 22'h012345, 1'b0, 1'b0, 1);
        check("bypass.reads", rd_q.size(), 0);
        check("bypass.writes", n_wr, 0);

        // Two-level walk
        clr();
        mem[L1A] = 32'h0004_0001;
        mem[L0A] = 32'h2000_00CF;
        walk("two_level", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h080000, 1'b0, 1'b0, 5);
        check("two_level.nrd", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            check("two_level.rd0", rd_q[0], L1A);
            check("two_level.rd1", rd_q[1], L0A);
        end
        check("two_level.nwr", n_wr, 0);

        // Superpage store with D=0: A/D write-back
        clr();
        mem[L1A] = 32'h2000_0047;
        walk("ad_store", 1'b1, 32'h0040_3000, 2'd2, 2'd1, 1'b0, 1'b0, 22'h080003, 1'b1, 1'b0, 5);
        check("ad_store.nwr", n_wr, 1);
        check("ad_store.waddr", wr_addr, L1A);
        check("ad_store.wdata", wr_data, 32'h2000_00C7);

        clr();
        mem[L1A] = 32'h2000_0047;
        walk("ad_acc3", 1'b1, 32'h0040_3000, 2'd3, 2'd1, 1'b0, 1'b0, 22'h080003, 1'b1, 1'b0, 5);
        check("ad_acc3.wdata", wr_data, 32'h2000_00C7);

        clr();
        mem[L1A] = 32'h2000_000B;
        walk("ad_load", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h080003, 1'b1, 1'b0, 5);
        check("ad_load.wdata", wr_data, 32'h2000_004B);

        clr();
        mem[L1A] = 32'h2000_00C7;
        walk("no_ad", 1'b1, 32'h0040_3000, 2'd2, 2'd1, 1'b0, 1'b0, 22'h080003, 1'b1, 1'b0, 3);
        check("no_ad.nwr", n_wr, 0);

        // Faults: none may write memory
        clr();
        mem[L1A_0] = 32'h0000_0005;
        walk("f_rsvd", 1'b1, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A_0] = 32'h0000_0004;
        walk("f_inval", 1'b1, 32'h0, 2'd1, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A_0] = 32'h2000_00C3;
        walk("f_nox", 1'b1, 32'h0, 2'd0, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A_0] = 32'h0000_04CF;
        walk("f_misal", 1'b1, 32'h0, 2'd1, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A_0] = 32'h0000_0003;
        walk("f_u_noa", 1'b1, 32'h0, 2'd1, 2'd0, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A] = 32'h0004_0001;
        mem[L0A] = 32'h0000_0001;
        walk("f_l0ptr", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 5);
        check("faults.nwr", n_wr, 0);

        // Privilege, SUM and MXR
        clr();
        mem[L1A] = 32'h2000_00CF;
        walk("p_u_nou", 1'b1, 32'h0040_3000, 2'd1, 2'd0, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A] = 32'h2000_00DF;
        walk("p_u_ok", 1'b1, 32'h0040_3000, 2'd1, 2'd0, 1'b0, 1'b0, 22'h080003, 1'b1, 1'b0, 3);
        walk("p_s_nosum", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        walk("p_s_sum", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b1, 1'b0, 22'h080003, 1'b1, 1'b0, 3);
        walk("p_s_fetch", 1'b1, 32'h0040_3000, 2'd0, 2'd1, 1'b1, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        mem[L1A] = 32'h2000_00C9;
        walk("p_nomxr", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);
        walk("p_mxr", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b1, 22'h080003, 1'b1, 1'b0, 3);
        mem[L1A] = 32'h2000_00CB;
        walk("p_store_now", 1'b1, 32'h0040_3000, 2'd2, 2'd1, 1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 3);

        // Flush while the response is pending
        clr();
        start_req("fl_done", 1'b0, 32'h0000_5000, 2'd1, 2'd1, 1'b0, 1'b0);
        wait_resp("fl_done", lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_done.state", {resp_valid, req_ready}, 2'b01);

        // Flush in L0_WAIT with a late memory response
        clr();
        mem[L1A] = 32'h0004_0001;
        mem[L0A] = 32'h2000_00CF;
        slow_addr = L0A;
        start_req("fl_wait", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("fl_wait.nrd", rd_q.size(), 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen_rv = 1'b0;
        t_resp  = -1;
        t_rdy   = -1;
        for (int i = 0; i < 20 && t_rdy < 0; i++) begin
            @(negedge clk);
            if (resp_valid) seen_rv = 1'b1;
            if (mem_resp_valid && t_resp < 0) t_resp = i;
            if (req_ready) t_rdy = i;
        end
        check("fl_wait.no_resp", seen_rv, 1'b0);
        check("fl_wait.t_resp", t_resp, 2);
        check("fl_wait.t_ready", t_rdy, 3);
        slow_addr = '1;
        @(posedge clk); #1;
        clr();
        mem[L1A] = 32'h0004_0001;
        mem[L0A] = 32'h2000_00CF;
        walk("after_flush", 1'b1, 32'h0040_3000, 2'd1, 2'd1, 1'b0, 1'b0, 22'h080000, 1'b0, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
